rx_frame_fifo: RTL
==================

Name: rx_frame_fifo

Overview:
- Receive-side frame buffer directly downstream of the UART receiver.
- Captures each completed frame, i.e. P_DATA_OUT plus its parity_error and stop_error flags, on the receiver's DATA_VALID indication.
- Stores frames in a DEPTH-entry circular FIFO and presents them to the host/bus side with a valid/ready read handshake.
- Keeps a sticky overflow flag and a saturating count of errored frames.

Parameters:
- DATA_WIDTH, 4, frame payload width; must match the receiver's DATA_WIDTH.
- DEPTH, 8, FIFO entries; power of two, ≥2.
- DROP_ERR, 0; 1 = frames with parity or stop error are counted but not stored; 0 = stored with their flags.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- DATA_VALID  in  1  frame-complete indication from the receiver.
- P_DATA_OUT  in  DATA_WIDTH  received payload, valid while DATA_VALID=1.
- parity_error  in  1  parity error flag for the current frame.
- stop_error  in  1  stop error flag for the current frame.
- rd_ready  in  1  consumer accepts the head entry.
- rd_valid  out  1  head entry available.
- rd_data  out  DATA_WIDTH  head entry payload.
- rd_par_err  out  1  head entry parity error flag.
- rd_stop_err  out  1  head entry stop error flag.
- count  out  $clog2(DEPTH)+1  entries currently stored.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- overflow  out  1  sticky: a frame was lost because the FIFO was full.
- err_cnt  out  8  errored frames seen, saturating at 255.
- stat_clr  in  1  synchronous clear of overflow and err_cnt.

Behaviour:
- Reset (rst=0, asynchronous):
  - Pointers and count are cleared; dv_q=0.
  - Outputs: rd_valid=0, empty=1, full=0, count=0, overflow=0, err_cnt=0.
  - rd_data, rd_par_err and rd_stop_err read 0 while empty.
  - Reset mid-frame discards all stored entries.
- Capture event:
  - cap = DATA_VALID & ~dv_q, where dv_q is DATA_VALID registered.
  - A DATA_VALID held high for several cycles gives exactly one capture, on its first cycle.
  - Two pulses separated by at least one low cycle give two captures.
- Entry format: {stop_error, parity_error, P_DATA_OUT}, width DATA_WIDTH+2, sampled in the cap cycle.
- Write:
  - wr = cap & ~(DROP_ERR & (parity_error | stop_error)).
  - If wr and the FIFO is not full, the entry goes to mem[wptr] and wptr increments.
- Read, first-word-fall-through:
  - rd_valid = ~empty; rd_data and the flags come from mem[rptr] combinationally.
  - pop = rd_valid & rd_ready; on pop, rptr increments.
  - Latency: a cap at edge T gives rd_valid=1 after edge T, i.e. visible in cycle T+1.
- Pointers: $clog2(DEPTH) bits and wrap naturally; the full/empty distinction comes from count.
- Count update: +1 on an accepted write only, −1 on a pop only, unchanged when both occur.
- Simultaneous events:
  - Full with write and pop in the same cycle: the write is accepted, no overflow, count stays DEPTH.
  - Empty with a write: no pop is possible that cycle (rd_valid=0), so the entry appears the next cycle.
  - Full with a write and no pop: the entry is dropped, overflow is set next cycle, stored data is unchanged.
- err_cnt:
  - Increments on every cap with parity_error|stop_error, independent of DROP_ERR and of full.
  - Holds at 255.
- stat_clr: clears overflow and err_cnt next cycle. If a set or increment condition occurs in the same cycle, the set wins: overflow=1 and err_cnt=1.
- rd_ready while empty has no effect.
- No state machine beyond the pointer, count and edge-detect registers. Only the counters, flags and pointers are reset; mem is not reset.

Decomposition:
- Shared package, uart_pkg:
  - Entry-width localparam (DATA_WIDTH+2).
  - Flag bit positions within the entry (PAR_BIT, STOP_BIT).
  - ERR_CNT_W=8.
- Sub-module rx_fifo_mem:
  - Generic DEPTH×W register array.
  - One synchronous write port and one asynchronous read port.
  - Instantiated once.
- The top level holds the edge detect, pointers, count, flags and counter.

Test Plan:
- Reset, then three clean frames 0x3, 0xA, 0x5 as 1-cycle DATA_VALID pulses with rd_ready=0 -> count=3, rd_valid=1, rd_data=0x3; then rd_ready=1 for 3 cycles -> outputs 0x3, 0xA, 0x5 in order, then empty=1.
- DATA_VALID held high 4 cycles with P_DATA_OUT=0x7 -> exactly one entry, count=1.
- 9 frames 0x0..0x8 with rd_ready=0, DEPTH=8 -> full=1, count=8, overflow=1, and the entries read back are 0x0..0x7; stat_clr -> overflow=0.
- Full FIFO; frame 0xF arrives in the same cycle as a pop -> no overflow, count stays 8, and 0xF is the last entry read.
- Frame 0x6 with parity_error=1, DROP_ERR=0 -> rd_par_err=1 with rd_data=0x6, err_cnt=1; same stimulus with DROP_ERR=1 -> count=0, err_cnt=1.
- 300 errored frames -> err_cnt=255; assert rst low mid-sequence -> all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: entry layout of the frame FIFO
// and width of the errored-frame counter.
package uart_pkg;

   localparam int FLAG_BITS = 2;
   localparam int ERR_CNT_W = 8;

   function automatic int entry_w(input int dw);
      return dw + FLAG_BITS;
   endfunction

   // Flags sit directly above the payload: {stop_error, parity_error, payload}
   function automatic int par_bit(input int dw);
      return dw;
   endfunction

   function automatic int stop_bit(input int dw);
      return dw + 1;
   endfunction

endpackage

// File: rtl/rx_fifo_mem.sv
// DEPTH x W register array: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; validity is tracked by the owner.
module rx_fifo_mem #(
   parameter int DEPTH = 8,
   parameter int W     = 6,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          i_wr_en,
   input  logic [AW-1:0] i_wr_addr,
   input  logic [W-1:0]  i_wr_data,
   input  logic [AW-1:0] i_rd_addr,
   output logic [W-1:0]  o_rd_data
);

   logic [W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/rx_frame_fifo.sv
// Receive frame FIFO behind the UART receiver: one capture per DATA_VALID rising edge,
// first-word-fall-through read handshake, sticky overflow and saturating error count.
module rx_frame_fifo
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 4,
   parameter int DEPTH      = 8,
   parameter bit DROP_ERR   = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    DATA_VALID,
   input  logic [DATA_WIDTH-1:0]   P_DATA_OUT,
   input  logic                    parity_error,
   input  logic                    stop_error,
   input  logic                    rd_ready,
   output logic                    rd_valid,
   output logic [DATA_WIDTH-1:0]   rd_data,
   output logic                    rd_par_err,
   output logic                    rd_stop_err,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    full,
   output logic                    empty,
   output logic                    overflow,
   output logic [ERR_CNT_W-1:0]    err_cnt,
   input  logic                    stat_clr
);

   localparam int AW  = $clog2(DEPTH);
   localparam int CW  = AW + 1;
   localparam int EW  = entry_w(DATA_WIDTH);
   localparam int PB  = par_bit(DATA_WIDTH);
   localparam int SB  = stop_bit(DATA_WIDTH);

   logic                 r_dv_q;
   logic [AW-1:0]        r_wptr;
   logic [AW-1:0]        r_rptr;
   logic [CW-1:0]        r_count;
   logic                 r_overflow;
   logic [ERR_CNT_W-1:0] r_err_cnt;

   logic          w_cap;
   logic          w_err;
   logic          w_wr;
   logic          w_full;
   logic          w_empty;
   logic          w_pop;
   logic          w_wr_ok;
   logic          w_ovf_set;
   logic          w_err_inc;
   logic [EW-1:0] w_wr_entry;
   logic [EW-1:0] w_rd_entry;

   assign w_cap     = DATA_VALID & ~r_dv_q;
   assign w_err     = parity_error | stop_error;
   assign w_wr      = w_cap & ~(DROP_ERR & w_err);
   assign w_full    = (r_count == CW'(DEPTH));
   assign w_empty   = (r_count == '0);
   assign w_pop     = ~w_empty & rd_ready;
   // A pop in the same cycle frees the slot the full-FIFO write needs.
   assign w_wr_ok   = w_wr & (~w_full | w_pop);
   assign w_ovf_set = w_wr & w_full & ~w_pop;
   assign w_err_inc = w_cap & w_err;

   always_comb begin
      w_wr_entry                   = '0;
      w_wr_entry[DATA_WIDTH-1:0]   = P_DATA_OUT;
      w_wr_entry[PB]               = parity_error;
      w_wr_entry[SB]               = stop_error;
   end

   rx_fifo_mem #(
      .DEPTH (DEPTH),
      .W     (EW),
      .AW    (AW)
   ) u_mem (
      .clk       (clk),
      .i_wr_en   (w_wr_ok),
      .i_wr_addr (r_wptr),
      .i_wr_data (w_wr_entry),
      .i_rd_addr (r_rptr),
      .o_rd_data (w_rd_entry)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_dv_q  <= 1'b0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         r_dv_q <= DATA_VALID;
         if (w_wr_ok) r_wptr <= r_wptr + AW'(1);
         if (w_pop)   r_rptr <= r_rptr + AW'(1);
         case ({w_wr_ok, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Set/increment take priority over stat_clr in the same cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_overflow <= 1'b0;
         r_err_cnt  <= '0;
      end else begin
         if (w_ovf_set)     r_overflow <= 1'b1;
         else if (stat_clr) r_overflow <= 1'b0;

         if (w_err_inc) begin
            if (stat_clr)              r_err_cnt <= ERR_CNT_W'(1);
            else if (r_err_cnt != '1)  r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
         end else if (stat_clr) begin
            r_err_cnt <= '0;
         end
      end
   end

   assign rd_valid    = ~w_empty;
   assign rd_data     = w_empty ? '0   : w_rd_entry[DATA_WIDTH-1:0];
   assign rd_par_err  = w_empty ? 1'b0 : w_rd_entry[PB];
   assign rd_stop_err = w_empty ? 1'b0 : w_rd_entry[SB];
   assign count       = r_count;
   assign full        = w_full;
   assign empty       = w_empty;
   assign overflow    = r_overflow;
   assign err_cnt     = r_err_cnt;

endmodule
